// File: rtl/ddr_axi_rd_checker_if.sv
// rtl/ddr_axi_rd_checker_if.sv - AR snoop and R channel bundle for ddr_axi_rd_checker
interface ddr_axi_rd_checker_if #(
    parameter int AW = 26,
    parameter int DW = 16
);
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic          rvalid;
    logic          rready;
    logic          rlast;
    logic [DW-1:0] rdata;

    // Traffic source side: drives AR and R, observes rready
    modport master (
        output arvalid, arready, araddr, arlen, rvalid, rlast, rdata,
        input  rready
    );

    // Checker side: taps AR passively, consumes R
    modport slave (
        input  arvalid, arready, araddr, arlen, rvalid, rlast, rdata,
        output rready
    );
endinterface

// File: rtl/ddr_axi_rd_checker.sv
// rtl/ddr_axi_rd_checker.sv - AXI4 read-data pattern/rlast checker; optional RDCHK_BACKPRESSURE_EN random rready
module ddr_axi_rd_checker #(
    parameter int BA_BITS    = 2,
    parameter int ROW_BITS   = 13,
    parameter int COL_BITS   = 11,
    parameter int DQ_LEVEL   = 1,
    parameter int DESC_DEPTH = 4,
    parameter logic [(8<<DQ_LEVEL)-1:0] PATTERN_SEED = '0,
    localparam int DW = 8 << DQ_LEVEL,
    localparam int AW = BA_BITS + ROW_BITS + COL_BITS + DQ_LEVEL - 1
) (
    input  logic                core_clk,
    input  logic                core_rst,
    input  logic                clr,
    ddr_axi_rd_checker_if.slave bus,
    output logic                error_flag,
    output logic [15:0]         error_cnt,
    output logic [31:0]         beat_cnt,
    output logic [15:0]         burst_cnt,
    output logic [AW-1:0]       last_err_addr,
    output logic [2:0]          proto_err
);
    localparam int PW = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
    localparam logic [PW:0]   FULL_LVL = DESC_DEPTH[PW:0];
    localparam logic [PW:0]   C_ONE    = 1;
    localparam logic [PW-1:0] P_ONE    = 1;

    // Burst descriptor FIFO
    logic [AW-1:0] desc_addr [DESC_DEPTH];
    logic [7:0]    desc_len  [DESC_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [7:0]    beat_idx;

    // Current-beat decode
    logic          accept;
    logic          push;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW-1:0] head_addr;
    logic [7:0]    head_len;
    logic [AW-1:0] beat_addr;
    logic [DW-1:0] addr_pat;
    logic [DW-1:0] exp_data;
    logic          hit;
    logic          is_last;
    logic          pop;
    logic          push_ok;
    logic          ev_orphan;
    logic          ev_early;
    logic          ev_missing;
    logic          ev_done;

    // Result stage: events captured at the accepting edge, applied one edge later
    logic          s_beat;
    logic          s_mis;
    logic [AW-1:0] s_addr;
    logic          s_early;
    logic          s_missing;
    logic          s_done;
    logic          s_orphan;

    logic          mis_sticky;

    // Expected data is the beat address fitted to the data width
    generate
        if (DW <= AW) begin : g_pat_trunc
            assign addr_pat = beat_addr[DW-1:0];
        end else begin : g_pat_zext
            assign addr_pat = {{(DW-AW){1'b0}}, beat_addr};
        end
    endgenerate

    // Decode handshakes, head descriptor and rlast conditions for this cycle
    always_comb begin
        accept     = bus.rvalid && bus.rready;
        push       = bus.arvalid && bus.arready;
        fifo_empty = (count == '0);
        fifo_full  = (count == FULL_LVL);
        head_addr  = desc_addr[rd_ptr];
        head_len   = desc_len[rd_ptr];
        beat_addr  = head_addr + (AW'(beat_idx) << DQ_LEVEL);
        exp_data   = addr_pat ^ PATTERN_SEED;
        is_last    = (beat_idx == head_len);
        hit        = accept && !fifo_empty;
        ev_early   = hit && bus.rlast && !is_last;
        ev_missing = hit && is_last && !bus.rlast;
        ev_done    = hit && is_last && bus.rlast;
        pop        = hit && (bus.rlast || is_last);
        // A full FIFO still takes a push when the head leaves in the same cycle
        push_ok    = push && (!fifo_full || pop);
        // Beats against an empty FIFO (including a same-cycle push) are orphans
        ev_orphan  = (accept && fifo_empty) || (push && !push_ok);
    end

    // Descriptor storage, written on accepted AR snoops
    always_ff @(posedge core_clk) begin
        if (push_ok) begin
            desc_addr[wr_ptr] <= bus.araddr;
            desc_len[wr_ptr]  <= bus.arlen;
        end
    end

    // FIFO pointers, occupancy and beat index within the head burst
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_idx <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + P_ONE;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + P_ONE;
                beat_idx <= '0;
            end else if (hit) begin
                beat_idx <= beat_idx + 8'd1;
            end
            if (push_ok && !pop) begin
                count <= count + C_ONE;
            end else if (pop && !push_ok) begin
                count <= count - C_ONE;
            end
        end
    end

    // Register compare result and protocol events of the accepted beat
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            s_beat    <= 1'b0;
            s_mis     <= 1'b0;
            s_addr    <= '0;
            s_early   <= 1'b0;
            s_missing <= 1'b0;
            s_done    <= 1'b0;
            s_orphan  <= 1'b0;
        end else begin
            s_beat    <= accept;
            s_mis     <= hit && (bus.rdata != exp_data);
            s_addr    <= beat_addr;
            s_early   <= ev_early;
            s_missing <= ev_missing;
            s_done    <= ev_done;
            s_orphan  <= ev_orphan;
        end
    end

    // Counters and sticky flags; clr wins over any update landing this edge
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            error_cnt     <= '0;
            beat_cnt      <= '0;
            burst_cnt     <= '0;
            last_err_addr <= '0;
            proto_err     <= '0;
            mis_sticky    <= 1'b0;
        end else if (clr) begin
            error_cnt     <= '0;
            beat_cnt      <= '0;
            burst_cnt     <= '0;
            last_err_addr <= '0;
            proto_err     <= '0;
            mis_sticky    <= 1'b0;
        end else begin
            if (s_beat) begin
                beat_cnt <= beat_cnt + 32'd1;
            end
            if (s_done) begin
                burst_cnt <= burst_cnt + 16'd1;
            end
            if (s_mis) begin
                if (error_cnt != 16'hFFFF) begin
                    error_cnt <= error_cnt + 16'd1;
                end
                mis_sticky    <= 1'b1;
                last_err_addr <= s_addr;
            end
            proto_err <= proto_err | {s_orphan, s_missing, s_early};
        end
    end

    assign error_flag = mis_sticky | (|proto_err);

`ifdef RDCHK_BACKPRESSURE_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic [1:0]  low_run;
    logic        rready_nxt;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1; low runs are capped at three cycles
    always_comb begin
        lfsr_nxt   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        rready_nxt = lfsr_nxt[0] || (!bus.rready && (low_run == 2'd3));
    end

    // Random rready; low_run counts consecutive low cycles including the current one
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            lfsr       <= 16'hACE1;
            low_run    <= 2'd1;
            bus.rready <= 1'b0;
        end else begin
            lfsr       <= lfsr_nxt;
            bus.rready <= rready_nxt;
            if (rready_nxt) begin
                low_run <= 2'd0;
            end else if (bus.rready) begin
                low_run <= 2'd1;
            end else begin
                low_run <= low_run + 2'd1;
            end
        end
    end
`else
    // Always ready once out of reset
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            bus.rready <= 1'b0;
        end else begin
            bus.rready <= 1'b1;
        end
    end
`endif

endmodule
